// File: rtl/byte_responder_slave.sv
// ---------------------------------------------------------------------------
// byte_responder_slave
//
// AXI4 INCR-burst slave memory responder. It accepts write bursts into an
// internal byte-enabled word RAM and serves read bursts from that RAM. The
// write and read paths are two independent FSMs that share the one RAM.
//
// Handshake rule (all five channels): a transfer happens on the rising edge
// where both VALID and READY are high. Once a VALID is raised by this block,
// it and its payload stay constant until the matching READY is seen.
//
// Ports
//   ACLK, ARESET           clock (rising edge), async active-high reset
//   S_AXI_AW*              write address channel (ADDR, LEN, VALID/READY)
//   S_AXI_W*               write data channel (DATA, STRB, LAST, VALID/READY)
//   S_AXI_B*               write response channel (RESP, VALID/READY)
//   S_AXI_AR*              read address channel (ADDR, LEN, VALID/READY)
//   S_AXI_R*               read data channel (DATA, RESP, LAST, VALID/READY)
//   w_state_dbg            current write FSM state (0 idle, 1 data, 2 resp)
//   r_state_dbg            current read FSM state (0 idle, 1 data)
//
// Optional feature macro: BYTE_RESP_PROTCHK_EN
//   Undefined: WLAST ignored, BRESP/RRESP always OKAY, addresses alias
//              modulo the RAM size.
//   Defined:   a WLAST that disagrees with AWLEN gives BRESP=SLVERR; a burst
//              starting at or above MEM_WORDS*4 suppresses its writes
//              (BRESP=SLVERR) or reads back zero with RRESP=SLVERR per beat.
// ---------------------------------------------------------------------------
module byte_responder_slave #(
    parameter int C_S_AXI_DATA_WIDTH = 32,
    parameter int C_S_AXI_ADDR_WIDTH = 12,
    parameter int MEM_WORDS          = 256
) (
    input  logic                            ACLK,
    input  logic                            ARESET,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_AWADDR,
    input  logic [7:0]                      S_AXI_AWLEN,
    input  logic                            S_AXI_AWVALID,
    output logic                            S_AXI_AWREADY,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_WDATA,
    input  logic [C_S_AXI_DATA_WIDTH/8-1:0] S_AXI_WSTRB,
    input  logic                            S_AXI_WLAST,
    input  logic                            S_AXI_WVALID,
    output logic                            S_AXI_WREADY,
    output logic [1:0]                      S_AXI_BRESP,
    output logic                            S_AXI_BVALID,
    input  logic                            S_AXI_BREADY,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_ARADDR,
    input  logic [7:0]                      S_AXI_ARLEN,
    input  logic                            S_AXI_ARVALID,
    output logic                            S_AXI_ARREADY,
    output logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_RDATA,
    output logic [1:0]                      S_AXI_RRESP,
    output logic                            S_AXI_RLAST,
    output logic                            S_AXI_RVALID,
    input  logic                            S_AXI_RREADY,
    output logic [1:0]                      w_state_dbg,
    output logic                            r_state_dbg
);

    localparam int DW     = C_S_AXI_DATA_WIDTH;
    localparam int AW     = C_S_AXI_ADDR_WIDTH;
    localparam int STRB_W = DW / 8;
    localparam int IDX_W  = $clog2(MEM_WORDS);

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [1:0] {
        W_IDLE = 2'd0,
        W_DATA = 2'd1,
        W_RESP = 2'd2
    } w_state_t;

    typedef enum logic {
        R_IDLE = 1'b0,
        R_DATA = 1'b1
    } r_state_t;

    // Word RAM; never reset so partially written bursts survive ARESET.
    logic [DW-1:0] mem [MEM_WORDS];

    w_state_t         w_state;
    logic [IDX_W-1:0] w_idx;
    logic [7:0]       w_len;
    logic [7:0]       w_cnt;
    logic             w_err;
    logic             w_drop;

    r_state_t         r_state;
    logic [IDX_W-1:0] r_idx;      // index of the next word to load
    logic [7:0]       r_len;
    logic [7:0]       r_cnt;      // beat number currently on RDATA
    logic             r_drop;

    logic [IDX_W-1:0] aw_idx;
    logic [IDX_W-1:0] ar_idx;
    logic             aw_oor;
    logic             ar_oor;
    logic             w_fire;
    logic             w_last_beat;
    logic             wlast_bad;
    logic             mem_we;
    logic [7:0]       r_next_cnt;

    // Byte address bits [1:0] select a byte inside the word; the index
    // naturally wraps modulo MEM_WORDS because MEM_WORDS is a power of 2.
    assign aw_idx = S_AXI_AWADDR[IDX_W+1:2];
    assign ar_idx = S_AXI_ARADDR[IDX_W+1:2];

`ifdef BYTE_RESP_PROTCHK_EN
    function automatic logic addr_oor(input logic [AW-1:0] a);
        return (a >> (IDX_W + 2)) != '0;
    endfunction

    assign aw_oor    = addr_oor(S_AXI_AWADDR);
    assign ar_oor    = addr_oor(S_AXI_ARADDR);
    assign wlast_bad = (S_AXI_WLAST != w_last_beat);

    logic unused_addr_lsb;
    assign unused_addr_lsb = ^{S_AXI_AWADDR[1:0], S_AXI_ARADDR[1:0]};
`else
    assign aw_oor    = 1'b0;
    assign ar_oor    = 1'b0;
    assign wlast_bad = 1'b0;

    logic unused_inputs;
    assign unused_inputs = ^{S_AXI_AWADDR, S_AXI_ARADDR, S_AXI_WLAST};
`endif

    assign w_fire      = (w_state == W_DATA) && S_AXI_WREADY && S_AXI_WVALID;
    assign w_last_beat = (w_cnt == w_len);
    assign mem_we      = w_fire && !w_drop;
    assign r_next_cnt  = r_cnt + 8'd1;

    assign w_state_dbg = w_state;
    assign r_state_dbg = r_state;

    // -----------------------------------------------------------------------
    // Write FSM
    // -----------------------------------------------------------------------
    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            w_state       <= W_IDLE;
            S_AXI_AWREADY <= 1'b0;
            S_AXI_WREADY  <= 1'b0;
            S_AXI_BVALID  <= 1'b0;
            S_AXI_BRESP   <= RESP_OKAY;
            w_idx         <= '0;
            w_len         <= '0;
            w_cnt         <= '0;
            w_err         <= 1'b0;
            w_drop        <= 1'b0;
        end else begin
            case (w_state)
                W_IDLE: begin
                    if (S_AXI_AWREADY && S_AXI_AWVALID) begin
                        S_AXI_AWREADY <= 1'b0;
                        S_AXI_WREADY  <= 1'b1;
                        w_idx         <= aw_idx;
                        w_len         <= S_AXI_AWLEN;
                        w_cnt         <= '0;
                        w_drop        <= aw_oor;
                        w_err         <= aw_oor;
                        w_state       <= W_DATA;
                    end else begin
                        // AWREADY comes up on the first edge after reset.
                        S_AXI_AWREADY <= 1'b1;
                    end
                end
                W_DATA: begin
                    if (w_fire) begin
                        w_idx <= w_idx + 1'b1;
                        w_cnt <= w_cnt + 8'd1;
                        if (wlast_bad) begin
                            w_err <= 1'b1;
                        end
                        // Burst length is always taken from AWLEN, not WLAST.
                        if (w_last_beat) begin
                            S_AXI_WREADY <= 1'b0;
                            S_AXI_BVALID <= 1'b1;
                            S_AXI_BRESP  <= (w_err || wlast_bad) ? RESP_SLVERR : RESP_OKAY;
                            w_state      <= W_RESP;
                        end
                    end
                end
                W_RESP: begin
                    if (S_AXI_BREADY) begin
                        S_AXI_BVALID  <= 1'b0;
                        S_AXI_BRESP   <= RESP_OKAY;
                        S_AXI_AWREADY <= 1'b1;
                        w_state       <= W_IDLE;
                    end
                end
                default: begin
                    w_state <= W_IDLE;
                end
            endcase
        end
    end

    // RAM write port; byte lanes gated by WSTRB.
    always_ff @(posedge ACLK) begin
        if (mem_we) begin
            for (int b = 0; b < STRB_W; b++) begin
                if (S_AXI_WSTRB[b]) begin
                    mem[w_idx][8*b +: 8] <= S_AXI_WDATA[8*b +: 8];
                end
            end
        end
    end

    // -----------------------------------------------------------------------
    // Read FSM. RDATA is loaded from the RAM on the AR handshake edge and on
    // every accepted beat, so a read colliding with a write of the same word
    // in one cycle returns the pre-write contents.
    // -----------------------------------------------------------------------
    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            r_state       <= R_IDLE;
            S_AXI_ARREADY <= 1'b0;
            S_AXI_RVALID  <= 1'b0;
            S_AXI_RDATA   <= '0;
            S_AXI_RRESP   <= RESP_OKAY;
            S_AXI_RLAST   <= 1'b0;
            r_idx         <= '0;
            r_len         <= '0;
            r_cnt         <= '0;
            r_drop        <= 1'b0;
        end else begin
            case (r_state)
                R_IDLE: begin
                    if (S_AXI_ARREADY && S_AXI_ARVALID) begin
                        S_AXI_ARREADY <= 1'b0;
                        S_AXI_RVALID  <= 1'b1;
                        S_AXI_RLAST   <= (S_AXI_ARLEN == 8'd0);
                        S_AXI_RDATA   <= ar_oor ? '0 : mem[ar_idx];
                        S_AXI_RRESP   <= ar_oor ? RESP_SLVERR : RESP_OKAY;
                        r_idx         <= ar_idx + 1'b1;
                        r_len         <= S_AXI_ARLEN;
                        r_cnt         <= '0;
                        r_drop        <= ar_oor;
                        r_state       <= R_DATA;
                    end else begin
                        S_AXI_ARREADY <= 1'b1;
                    end
                end
                R_DATA: begin
                    // Without RREADY nothing moves, so the beat stays stable.
                    if (S_AXI_RREADY) begin
                        if (S_AXI_RLAST) begin
                            S_AXI_RVALID  <= 1'b0;
                            S_AXI_RLAST   <= 1'b0;
                            S_AXI_RRESP   <= RESP_OKAY;
                            S_AXI_ARREADY <= 1'b1;
                            r_state       <= R_IDLE;
                        end else begin
                            S_AXI_RDATA <= r_drop ? '0 : mem[r_idx];
                            S_AXI_RLAST <= (r_next_cnt == r_len);
                            r_idx       <= r_idx + 1'b1;
                            r_cnt       <= r_next_cnt;
                        end
                    end
                end
                default: begin
                    r_state <= R_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_byte_responder_slave.sv
// ---------------------------------------------------------------------------
// tb_byte_responder_slave
//
// Directed bench for byte_responder_slave: write bursts, byte strobes, index
// wrap, response back-pressure, read stalls, mid-burst reset and the
// protocol-check option (expectations follow BYTE_RESP_PROTCHK_EN).
// ---------------------------------------------------------------------------
module tb_byte_responder_slave;

  logic        ACLK = 1'b0;
  logic        ARESET;
  logic [11:0] S_AXI_AWADDR;
  logic [7:0]  S_AXI_AWLEN;
  logic        S_AXI_AWVALID;
  logic        S_AXI_AWREADY;
  logic [31:0] S_AXI_WDATA;
  logic [3:0]  S_AXI_WSTRB;
  logic        S_AXI_WLAST;
  logic        S_AXI_WVALID;
  logic        S_AXI_WREADY;
  logic [1:0]  S_AXI_BRESP;
  logic        S_AXI_BVALID;
  logic        S_AXI_BREADY;
  logic [11:0] S_AXI_ARADDR;
  logic [7:0]  S_AXI_ARLEN;
  logic        S_AXI_ARVALID;
  logic        S_AXI_ARREADY;
  logic [31:0] S_AXI_RDATA;
  logic [1:0]  S_AXI_RRESP;
  logic        S_AXI_RLAST;
  logic        S_AXI_RVALID;
  logic        S_AXI_RREADY;
  logic [1:0]  w_state_dbg;
  logic        r_state_dbg;

  int tests = 0;
  int fails = 0;

  logic [31:0] exp_q[$];
  logic [31:0] wd[16];
  logic [3:0]  ws[16];

  byte_responder_slave #(
    .C_S_AXI_DATA_WIDTH(32),
    .C_S_AXI_ADDR_WIDTH(12),
    .MEM_WORDS(256)
  ) dut (
    .ACLK(ACLK),
    .ARESET(ARESET),
    .S_AXI_AWADDR(S_AXI_AWADDR),
    .S_AXI_AWLEN(S_AXI_AWLEN),
    .S_AXI_AWVALID(S_AXI_AWVALID),
    .S_AXI_AWREADY(S_AXI_AWREADY),
    .S_AXI_WDATA(S_AXI_WDATA),
    .S_AXI_WSTRB(S_AXI_WSTRB),
    .S_AXI_WLAST(S_AXI_WLAST),
    .S_AXI_WVALID(S_AXI_WVALID),
    .S_AXI_WREADY(S_AXI_WREADY),
    .S_AXI_BRESP(S_AXI_BRESP),
    .S_AXI_BVALID(S_AXI_BVALID),
    .S_AXI_BREADY(S_AXI_BREADY),
    .S_AXI_ARADDR(S_AXI_ARADDR),
    .S_AXI_ARLEN(S_AXI_ARLEN),
    .S_AXI_ARVALID(S_AXI_ARVALID),
    .S_AXI_ARREADY(S_AXI_ARREADY),
    .S_AXI_RDATA(S_AXI_RDATA),
    .S_AXI_RRESP(S_AXI_RRESP),
    .S_AXI_RLAST(S_AXI_RLAST),
    .S_AXI_RVALID(S_AXI_RVALID),
    .S_AXI_RREADY(S_AXI_RREADY),
    .w_state_dbg(w_state_dbg),
    .r_state_dbg(r_state_dbg)
  );

  // clock / watchdog
  always #5 ACLK = ~ACLK;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_awready"}, S_AXI_AWREADY, 0);
    check({tag, "_wready"},  S_AXI_WREADY,  0);
    check({tag, "_bvalid"},  S_AXI_BVALID,  0);
    check({tag, "_bresp"},   S_AXI_BRESP,   0);
    check({tag, "_arready"}, S_AXI_ARREADY, 0);
    check({tag, "_rvalid"},  S_AXI_RVALID,  0);
    check({tag, "_rdata"},   S_AXI_RDATA,   0);
    check({tag, "_rresp"},   S_AXI_RRESP,   0);
    check({tag, "_rlast"},   S_AXI_RLAST,   0);
  endtask

  // driver tasks; all are entered and left 1 time unit after a rising edge
  task automatic do_aw(input logic [11:0] addr, input logic [7:0] len);
    int n = 0;
    S_AXI_AWADDR = addr;
    S_AXI_AWLEN = len;
    S_AXI_AWVALID = 1'b1;
    while (!S_AXI_AWREADY && n < 20) begin @(posedge ACLK); #1; n++; end
    check("awready", S_AXI_AWREADY, 1);
    @(posedge ACLK); #1;
    S_AXI_AWVALID = 1'b0;
  endtask

  task automatic do_w(input logic [7:0] len, input int last_at);
    int n;
    for (int i = 0; i <= int'(len); i++) begin
      S_AXI_WDATA = wd[i];
      S_AXI_WSTRB = ws[i];
      S_AXI_WLAST = (i == last_at);
      S_AXI_WVALID = 1'b1;
      n = 0;
      while (!S_AXI_WREADY && n < 20) begin @(posedge ACLK); #1; n++; end
      check("wready", S_AXI_WREADY, 1);
      @(posedge ACLK); #1;
    end
    S_AXI_WVALID = 1'b0;
    S_AXI_WLAST = 1'b0;
  endtask

  task automatic do_b(input logic [1:0] exp_resp, input int stall);
    int n = 0;
    S_AXI_BREADY = 1'b0;
    while (!S_AXI_BVALID && n < 20) begin @(posedge ACLK); #1; n++; end
    check("bvalid", S_AXI_BVALID, 1);
    for (int k = 0; k < stall; k++) begin
      check("bvalid_hold", S_AXI_BVALID, 1);
      check("bresp_hold", S_AXI_BRESP, exp_resp);
      check("wready_in_resp", S_AXI_WREADY, 0);
      @(posedge ACLK); #1;
    end
    S_AXI_BREADY = 1'b1;
    check("bresp", S_AXI_BRESP, exp_resp);
    @(posedge ACLK); #1;
    S_AXI_BREADY = 1'b0;
    check("bvalid_clear", S_AXI_BVALID, 0);
    check("w_state_idle", w_state_dbg, 0);
  endtask

  task automatic write_burst(input logic [11:0] addr, input logic [7:0] len,
                             input logic [1:0] exp_resp, input int stall);
    do_aw(addr, len);
    do_w(len, int'(len));
    do_b(exp_resp, stall);
  endtask

  // Read a burst and compare each beat against the front of exp_q.
  task automatic do_read(input logic [11:0] addr, input logic [7:0] len,
                         input logic [1:0] exp_resp, input bit toggle);
    int n = 0;
    logic [31:0] d;
    logic l;
    S_AXI_ARADDR = addr;
    S_AXI_ARLEN = len;
    S_AXI_ARVALID = 1'b1;
    while (!S_AXI_ARREADY && n < 20) begin @(posedge ACLK); #1; n++; end
    check("arready", S_AXI_ARREADY, 1);
    @(posedge ACLK); #1;
    S_AXI_ARVALID = 1'b0;
    check("rvalid_latency", S_AXI_RVALID, 1);
    for (int i = 0; i <= int'(len); i++) begin
      n = 0;
      while (!S_AXI_RVALID && n < 20) begin @(posedge ACLK); #1; n++; end
      check("rvalid", S_AXI_RVALID, 1);
      if (toggle) begin
        S_AXI_RREADY = 1'b0;
        d = S_AXI_RDATA;
        l = S_AXI_RLAST;
        @(posedge ACLK); #1;
        check("rvalid_stall", S_AXI_RVALID, 1);
        check("rdata_stable", S_AXI_RDATA, d);
        check("rlast_stable", S_AXI_RLAST, l);
      end
      if (exp_q.size() > 0) begin
        check("rdata", S_AXI_RDATA, exp_q.pop_front());
      end else begin
        check("exp_q_empty", 1, 0);
      end
      check("rlast", S_AXI_RLAST, (i == int'(len)));
      check("rresp", S_AXI_RRESP, exp_resp);
      S_AXI_RREADY = 1'b1;
      @(posedge ACLK); #1;
    end
    S_AXI_RREADY = 1'b0;
    check("rvalid_end", S_AXI_RVALID, 0);
    check("r_state_idle", r_state_dbg, 0);
  endtask

  initial begin
    ARESET = 1'b1;
    S_AXI_AWADDR = '0;  S_AXI_AWLEN = '0;  S_AXI_AWVALID = 1'b0;
    S_AXI_WDATA = '0;   S_AXI_WSTRB = '0;  S_AXI_WLAST = 1'b0;  S_AXI_WVALID = 1'b0;
    S_AXI_BREADY = 1'b0;
    S_AXI_ARADDR = '0;  S_AXI_ARLEN = '0;  S_AXI_ARVALID = 1'b0;
    S_AXI_RREADY = 1'b0;
    for (int i = 0; i < 16; i++) begin wd[i] = '0; ws[i] = 4'hF; end

    // reset state
    repeat (2) @(posedge ACLK);
    #1;
    check_all_zero("reset");
    check("reset_w_state", w_state_dbg, 0);
    check("reset_r_state", r_state_dbg, 0);
    ARESET = 1'b0;
    @(posedge ACLK); #1;
    check("awready_after_reset", S_AXI_AWREADY, 1);
    check("arready_after_reset", S_AXI_ARREADY, 1);

    // 1: four-beat write and readback
    wd[0] = 32'h11111111; wd[1] = 32'h22222222; wd[2] = 32'h33333333; wd[3] = 32'h44444444;
    write_burst(12'h010, 8'd3, 2'b00, 0);
    exp_q.push_back(32'h11111111); exp_q.push_back(32'h22222222);
    exp_q.push_back(32'h33333333); exp_q.push_back(32'h44444444);
    do_read(12'h010, 8'd3, 2'b00, 1'b0);

    // 2: byte strobes merge into an existing word
    wd[0] = 32'hAABBCCDD; ws[0] = 4'hF;
    write_burst(12'h000, 8'd0, 2'b00, 0);
    wd[0] = 32'h11223344; ws[0] = 4'b0101;
    write_burst(12'h000, 8'd0, 2'b00, 0);
    ws[0] = 4'hF;
    exp_q.push_back(32'hAA22CC44);
    do_read(12'h000, 8'd0, 2'b00, 1'b0);

    // 3 + 4: wrap 254,255,0,1 with BREADY held low 5 cycles
    wd[0] = 32'hCAFE0254; wd[1] = 32'hCAFE0255; wd[2] = 32'hCAFE0000; wd[3] = 32'hCAFE0001;
    write_burst(12'h3F8, 8'd3, 2'b00, 5);
    exp_q.push_back(32'hCAFE0000); exp_q.push_back(32'hCAFE0001);
    do_read(12'h000, 8'd1, 2'b00, 1'b0);
    exp_q.push_back(32'hCAFE0254); exp_q.push_back(32'hCAFE0255);
    exp_q.push_back(32'hCAFE0000); exp_q.push_back(32'hCAFE0001);
    do_read(12'h3F8, 8'd3, 2'b00, 1'b1);

    // 5: reset during write beat 3 of an eight-beat burst
    wd[0] = 32'hDEADBEEF;
    write_burst(12'h108, 8'd0, 2'b00, 0);
    do_aw(12'h100, 8'd7);
    S_AXI_WSTRB = 4'hF;
    S_AXI_WDATA = 32'hA0A0A0A0; S_AXI_WVALID = 1'b1;
    @(posedge ACLK); #1;
    S_AXI_WDATA = 32'hA1A1A1A1;
    @(posedge ACLK); #1;
    S_AXI_WDATA = 32'hA2A2A2A2;
    #1 ARESET = 1'b1;
    #1;
    check_all_zero("midburst_reset");
    S_AXI_WVALID = 1'b0;
    @(posedge ACLK); #1;
    ARESET = 1'b0;
    check("awready_before_edge", S_AXI_AWREADY, 0);
    @(posedge ACLK); #1;
    check("awready_after_release", S_AXI_AWREADY, 1);
    check("bvalid_after_release", S_AXI_BVALID, 0);
    exp_q.push_back(32'hA0A0A0A0); exp_q.push_back(32'hA1A1A1A1); exp_q.push_back(32'hDEADBEEF);
    do_read(12'h100, 8'd2, 2'b00, 1'b0);

    // 6: WLAST on beat 2 of a four-beat burst, then a high address read
    wd[0] = 32'h60000000; wd[1] = 32'h60000001; wd[2] = 32'h60000002; wd[3] = 32'h60000003;
    do_aw(12'h200, 8'd3);
    do_w(8'd3, 1);
`ifdef BYTE_RESP_PROTCHK_EN
    do_b(2'b10, 0);
`else
    do_b(2'b00, 0);
`endif
    exp_q.push_back(32'h60000000); exp_q.push_back(32'h60000001);
    exp_q.push_back(32'h60000002); exp_q.push_back(32'h60000003);
    do_read(12'h200, 8'd3, 2'b00, 1'b0);
`ifdef BYTE_RESP_PROTCHK_EN
    exp_q.push_back(32'h0); exp_q.push_back(32'h0);
    do_read(12'h800, 8'd1, 2'b10, 1'b0);
`else
    // 0x800 aliases onto word 0
    exp_q.push_back(32'hCAFE0000); exp_q.push_back(32'hCAFE0001);
    do_read(12'h800, 8'd1, 2'b00, 1'b0);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
